// File: rtl/md_controller_pkg.sv
// Shared opcodes and latency defaults for the EX-stage multiply/divide unit.
package md_controller_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MFHI  = 4'd5,
    MD_MFLO  = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8
  } md_op_e;

  localparam int MD_MULT_CYCLES = 5;
  localparam int MD_DIV_CYCLES  = 10;

endpackage

// File: rtl/md_controller_core.sv
// Combinational MD datapath: computes the {hi, lo} result an arithmetic op would commit.
module md_core
  import md_controller_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] data1,
  input  logic [31:0] data2,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo
);

  logic signed [63:0] w_prod_s;
  logic        [63:0] w_prod_u;
  logic signed [31:0] w_quo_s;
  logic signed [31:0] w_rem_s;
  logic        [31:0] w_quo_u;
  logic        [31:0] w_rem_u;
  logic        [31:0] w_dvs;
  logic               w_div0;
  logic               w_ovf;

  assign w_prod_s = $signed({{32{data1[31]}}, data1}) * $signed({{32{data2[31]}}, data2});
  assign w_prod_u = {32'd0, data1} * {32'd0, data2};

  // Divisor forced non-zero so the dividers never see 0; the result is discarded anyway.
  assign w_div0 = (data2 == 32'd0);
  assign w_dvs  = w_div0 ? 32'd1 : data2;
  assign w_ovf  = (data1 == 32'h8000_0000) && (data2 == 32'hFFFF_FFFF);

  assign w_quo_s = w_ovf ? $signed(32'h8000_0000) : ($signed(data1) / $signed(w_dvs));
  assign w_rem_s = w_ovf ? $signed(32'd0) : ($signed(data1) % $signed(w_dvs));
  assign w_quo_u = data1 / w_dvs;
  assign w_rem_u = data1 % w_dvs;

  always_comb begin
    res_hi = hi;
    res_lo = lo;
    case (op)
      MD_MULT: begin
        res_hi = w_prod_s[63:32];
        res_lo = w_prod_s[31:0];
      end
      MD_MULTU: begin
        res_hi = w_prod_u[63:32];
        res_lo = w_prod_u[31:0];
      end
      MD_DIV: begin
        if (!w_div0) begin
          res_hi = w_rem_s;
          res_lo = w_quo_s;
        end
      end
      MD_DIVU: begin
        if (!w_div0) begin
          res_hi = w_rem_u;
          res_lo = w_quo_u;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_controller.sv
// Multiply/divide sequencer: owns HI/LO, models op latency as a busy window, drives the MD stall term.
module md_controller
  import md_controller_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  op,
  input  logic [31:0] data1,
  input  logic [31:0] data2,
  output logic        start,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] out
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MULT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_DIV  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic [31:0]      r_pend_hi;
  logic [31:0]      r_pend_lo;
  logic [CNT_W-1:0] r_cnt;
  logic             w_is_mult;
  logic             w_is_div;
  logic [31:0]      w_res_hi;
  logic [31:0]      w_res_lo;

  assign w_is_mult = (op == MD_MULT) || (op == MD_MULTU);
  assign w_is_div  = (op == MD_DIV)  || (op == MD_DIVU);
  assign start     = (w_is_mult || w_is_div) && !busy;
  assign md_stall  = start || busy;

  always_comb begin
    out = 32'd0;
    if (op == MD_MFHI) out = r_hi;
    else if (op == MD_MFLO) out = r_lo;
  end

  md_core u_core (
    .op     (op),
    .data1  (data1),
    .data2  (data2),
    .hi     (r_hi),
    .lo     (r_lo),
    .res_hi (w_res_hi),
    .res_lo (w_res_lo)
  );

  // While busy, every incoming op (including MTHI/MTLO) is ignored; commit happens as cnt leaves 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_pend_hi <= 32'd0;
      r_pend_lo <= 32'd0;
      r_cnt     <= '0;
      busy      <= 1'b0;
    end else if (busy) begin
      if (r_cnt == CNT_ONE) begin
        r_hi  <= r_pend_hi;
        r_lo  <= r_pend_lo;
        r_cnt <= '0;
        busy  <= 1'b0;
      end else begin
        r_cnt <= r_cnt - CNT_ONE;
      end
    end else if (start) begin
      r_pend_hi <= w_res_hi;
      r_pend_lo <= w_res_lo;
      r_cnt     <= w_is_mult ? CNT_MULT : CNT_DIV;
      busy      <= 1'b1;
    end else if (op == MD_MTHI) begin
      r_hi <= data1;
    end else if (op == MD_MTLO) begin
      r_lo <= data1;
    end
  end

endmodule

// File: tb/tb_md_controller.sv
// Randomized and directed bench for md_controller against an arithmetic reference model.
module tb_md_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  op;
  logic [31:0] data1;
  logic [31:0] data2;
  logic        start;
  logic        busy;
  logic        md_stall;
  logic [31:0] out;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [31:0] m_hi, m_lo, m_ph, m_pl;
  int          m_left;

  md_controller dut (
    .clk      (clk),
    .reset    (reset),
    .op       (op),
    .data1    (data1),
    .data2    (data2),
    .start    (start),
    .busy     (busy),
    .md_stall (md_stall),
    .out      (out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_arith(input logic [3:0] o);
    return (o >= 4'd1) && (o <= 4'd4);
  endfunction

  task automatic model_reset();
    m_hi = 0; m_lo = 0; m_ph = 0; m_pl = 0; m_left = 0;
  endtask

  task automatic model_compute(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    m_ph = m_hi;
    m_pl = m_lo;
    case (o)
      4'd1: begin p = sa * sb; m_ph = p[63:32]; m_pl = p[31:0]; end
      4'd2: begin p = {32'd0, a} * {32'd0, b}; m_ph = p[63:32]; m_pl = p[31:0]; end
      4'd3: if (b != 0) begin q = sa / sb; r = sa % sb; m_pl = q[31:0]; m_ph = r[31:0]; end
      4'd4: if (b != 0) begin m_pl = a / b; m_ph = a % b; end
      default: ;
    endcase
    m_left = (o <= 4'd2) ? 5 : 10;
  endtask

  task automatic model_edge(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin m_hi = m_ph; m_lo = m_pl; end
    end else if (is_arith(o)) model_compute(o, a, b);
    else if (o == 4'd7) m_hi = a;
    else if (o == 4'd8) m_lo = a;
  endtask

  // One pipeline cycle: drive, check combinational/registered outputs at negedge, advance model at posedge.
  task automatic cyc(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    logic        e_start;
    logic [31:0] e_out;
    op = o; data1 = a; data2 = b;
    @(negedge clk);
    e_start = is_arith(o) && (m_left == 0);
    e_out   = (o == 4'd5) ? m_hi : (o == 4'd6) ? m_lo : 32'd0;
    chk("busy",  {31'd0, busy},     {31'd0, m_left > 0});
    chk("start", {31'd0, start},    {31'd0, e_start});
    chk("stall", {31'd0, md_stall}, {31'd0, e_start || (m_left > 0)});
    chk("out",   out, e_out);
    @(posedge clk);
    model_edge(o, a, b);
    #1;
  endtask

  task automatic idle(input int n, input logic [3:0] o);
    for (int i = 0; i < n; i++) cyc(o, 32'd0, 32'd0);
  endtask

  task automatic read_hilo(input string tag, input logic [31:0] eh, input logic [31:0] el);
    op = 4'd5; #1; chk({tag, "_hi"}, out, eh);
    op = 4'd6; #1; chk({tag, "_lo"}, out, el);
  endtask

  function automatic logic [31:0] rnd_data();
    logic [31:0] tbl [6];
    tbl[0] = 32'h0000_0000; tbl[1] = 32'hFFFF_FFFF; tbl[2] = 32'h8000_0000;
    tbl[3] = 32'h7FFF_FFFF; tbl[4] = 32'h0000_0001; tbl[5] = 32'h0000_0007;
    if ($urandom_range(0, 3) == 0) return tbl[$urandom_range(0, 5)];
    return $urandom();
  endfunction

  initial begin
    reset = 1'b1; op = 4'd0; data1 = 0; data2 = 0;
    model_reset();
    #12;
    read_hilo("rst", 32'd0, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;

    // MULT -1*2, MFHI during busy sees old hi
    cyc(4'd1, 32'hFFFF_FFFF, 32'd2);
    idle(5, 4'd5);
    read_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    cyc(4'd2, 32'hFFFF_FFFF, 32'd2);
    idle(5, 4'd6);
    read_hilo("multu", 32'h0000_0001, 32'hFFFF_FFFE);
    cyc(4'd3, 32'hFFFF_FFF9, 32'd2);
    idle(10, 4'd5);
    read_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    cyc(4'd4, 32'd7, 32'd2);
    idle(10, 4'd0);
    read_hilo("divu", 32'd1, 32'd3);
    cyc(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    idle(10, 4'd0);
    read_hilo("divovf", 32'd0, 32'h8000_0000);

    // div by zero keeps MTHI/MTLO values
    cyc(4'd7, 32'h1234, 32'd0);
    cyc(4'd8, 32'h5678, 32'd0);
    cyc(4'd4, 32'd7, 32'd0);
    idle(10, 4'd5);
    read_hilo("div0", 32'h1234, 32'h5678);

    // ops presented while busy are ignored
    cyc(4'd1, 32'd6, 32'd7);
    cyc(4'd0, 32'd0, 32'd0);
    cyc(4'd8, 32'hDEAD, 32'd0);
    cyc(4'd3, 32'd100, 32'd3);
    idle(2, 4'd6);
    read_hilo("ignore", 32'd0, 32'd42);

    // reset on busy cycle 3 of a DIV
    cyc(4'd3, 32'd50, 32'd7);
    idle(2, 4'd0);
    op = 4'd5; #2;
    reset = 1'b1; #1;
    model_reset();
    chk("rstmid_busy", {31'd0, busy}, 32'd0);
    read_hilo("rstmid", 32'd0, 32'd0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    cyc(4'd1, 32'd3, 32'd4);
    idle(5, 4'd6);
    read_hilo("post_rst", 32'd0, 32'd12);

    // random stream
    for (int i = 0; i < 600; i++) begin
      logic [3:0] o;
      o = 4'($urandom_range(0, 8));
      cyc(o, rnd_data(), ($urandom_range(0, 7) == 0) ? 32'd0 : rnd_data());
    end
    idle(12, 4'd5);
    read_hilo("final", m_hi, m_lo);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
